msrv32_hpm_unit: RTL and testbench

Parametrised machine-mode hardware performance monitor for the msrv32 core. Holds mcycle, minstret and NUM_COUNTERS programmable mhpmcounters with event selectors, mcountinhibit and a sticky overflow register, and exposes them through the same CSR read/write port style as msrv32_csr_file. The core's CSR file forwards accesses in the counter and event address ranges here and muxes csr_data_out back in when addr_hit_out is high.

---
 rtl/msrv32_hpm_pkg.sv | 43 ++++
 rtl/msrv32_hpm_counter.sv | 42 ++++
 rtl/msrv32_hpm_unit.sv | 143 ++++++++++++++
 tb/tb_msrv32_hpm_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_hpm_pkg.sv
// Shared definitions for the msrv32 hardware performance monitor.
// Covers the CSR address map, the csr_op encodings and the write-value computation.
package msrv32_hpm_pkg;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_MHPMOVF       = 12'h7C0;

  typedef enum logic [2:0] {
    CSR_OP_RW  = 3'b001,
    CSR_OP_RS  = 3'b010,
    CSR_OP_RC  = 3'b011,
    CSR_OP_RWI = 3'b101,
    CSR_OP_RSI = 3'b110,
    CSR_OP_RCI = 3'b111
  } csr_op_e;

  function automatic logic csr_op_writes(input logic [2:0] op);
    case (op)
      CSR_OP_RW, CSR_OP_RS, CSR_OP_RC,
      CSR_OP_RWI, CSR_OP_RSI, CSR_OP_RCI: csr_op_writes = 1'b1;
      default:                            csr_op_writes = 1'b0;
    endcase
  endfunction

  // The *I ops take the zero-extended immediate in place of the register operand
  function automatic logic [31:0] csr_wr_value(input logic [2:0]  op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] data,
                                               input logic [4:0]  uimm);
    logic [31:0] operand;
    operand = op[2] ? {27'b0, uimm} : data;
    case (op)
      CSR_OP_RW, CSR_OP_RWI: csr_wr_value = operand;
      CSR_OP_RS, CSR_OP_RSI: csr_wr_value = old_val | operand;
      CSR_OP_RC, CSR_OP_RCI: csr_wr_value = old_val & ~operand;
      default:               csr_wr_value = old_val;
    endcase
  endfunction

endpackage

// File: rtl/msrv32_hpm_counter.sv
// One performance counter of WIDTH bits (33..64) with half-word CSR writes.
// A write in the same cycle as an increment wins and drops the increment.
module msrv32_hpm_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_in,
  input  logic             wr_lo_in,
  input  logic             wr_hi_in,
  input  logic [31:0]      wr_data_in,
  output logic [WIDTH-1:0] count_out,
  output logic             wrap_out
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d  = count_q;
    wrap_out = 1'b0;
    if (wr_lo_in) begin
      count_d = {count_q[WIDTH-1:32], wr_data_in};
    end else if (wr_hi_in) begin
      // Upper write bits beyond WIDTH are discarded by the truncating cast
      count_d = WIDTH'({wr_data_in, count_q[31:0]});
    end else if (inc_in) begin
      count_d  = count_q + WIDTH'(1);
      wrap_out = &count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/msrv32_hpm_unit.sv
// Machine-mode performance monitor: mcycle, minstret, mhpmcounters with event
// selectors, mcountinhibit and a sticky overflow register behind a CSR port.
module msrv32_hpm_unit
  import msrv32_hpm_pkg::*;
#(
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_EVENTS    = 8
) (
  input  logic                  ms_riscv32_mp_clk_in,
  input  logic                  ms_riscv32_mp_rst_in,
  input  logic                  wr_en_in,
  input  logic [11:0]           csr_addr_in,
  input  logic [2:0]            csr_op_in,
  input  logic [4:0]            csr_uimm_in,
  input  logic [31:0]           csr_data_in,
  input  logic                  instret_inc_in,
  input  logic [NUM_EVENTS-1:0] event_in,
  output logic [31:0]           csr_data_out,
  output logic                  addr_hit_out,
  output logic                  ovf_irq_out
);

  localparam int NCNT = NUM_COUNTERS + 2;
  localparam int EW   = $clog2(NUM_EVENTS + 1);
  localparam logic [31:0] HPM_MASK = 32'(((64'd1 << NUM_COUNTERS) - 64'd1) << 3);
  localparam logic [31:0] INH_MASK = HPM_MASK | 32'h0000_0005;

  // Counter slot i sits at address/inhibit offset 0 (mcycle), 2 (minstret), 3+k
  function automatic int cnt_off(input int i);
    return (i == 0) ? 0 : i + 1;
  endfunction

  logic [COUNTER_WIDTH-1:0] cnt_val [NCNT];
  logic [NCNT-1:0]          cnt_wrap, cnt_inc, cnt_wr_lo, cnt_wr_hi, cnt_cond;
  logic [NUM_COUNTERS-1:0]  ev_hit;
  logic [EW-1:0]            event_q [NUM_COUNTERS];
  logic [EW-1:0]            event_d [NUM_COUNTERS];
  logic [31:0]              inh_q, inh_d, ovf_q, ovf_d, ovf_set, rd_data, wr_val;
  logic                     ovf_irq_q, ovf_irq_d, hit, wr_fire;

  always_comb begin
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      ev_hit[k] = 1'b0;
      for (int e = 0; e < NUM_EVENTS; e++) begin
        if (event_q[k] == EW'(e + 1)) ev_hit[k] = ev_hit[k] | event_in[e];
      end
    end
    cnt_cond = {ev_hit, instret_inc_in, 1'b1};
    for (int i = 0; i < NCNT; i++) begin
      cnt_inc[i] = cnt_cond[i] & ~inh_q[cnt_off(i)];
    end
  end

  always_comb begin : p_read
    logic [63:0] ext;
    rd_data = '0;
    hit     = 1'b0;
    ext     = '0;
    for (int i = 0; i < NCNT; i++) begin
      ext = 64'(cnt_val[i]);
      if (csr_addr_in == CSR_MCYCLE + 12'(cnt_off(i))) begin
        hit     = 1'b1;
        rd_data = ext[31:0];
      end
      if (csr_addr_in == CSR_MCYCLEH + 12'(cnt_off(i))) begin
        hit     = 1'b1;
        rd_data = ext[63:32];
      end
    end
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      if (csr_addr_in == CSR_MHPMEVENT3 + 12'(k)) begin
        hit     = 1'b1;
        rd_data = 32'(event_q[k]);
      end
    end
    if (csr_addr_in == CSR_MCOUNTINHIBIT) begin
      hit     = 1'b1;
      rd_data = inh_q;
    end
    if (csr_addr_in == CSR_MHPMOVF) begin
      hit     = 1'b1;
      rd_data = ovf_q;
    end
  end

  assign wr_fire = wr_en_in & csr_op_writes(csr_op_in) & hit;
  assign wr_val  = csr_wr_value(csr_op_in, rd_data, csr_data_in, csr_uimm_in);
  // Wrap bits of mcycle/minstret land on bits 1/2 and are masked away
  assign ovf_set = (32'(cnt_wrap) << 1) & HPM_MASK;

  always_comb begin
    inh_d     = inh_q;
    ovf_d     = ovf_q;
    event_d   = event_q;
    cnt_wr_lo = '0;
    cnt_wr_hi = '0;
    ovf_irq_d = |ovf_q;
    for (int i = 0; i < NCNT; i++) begin
      cnt_wr_lo[i] = wr_fire && (csr_addr_in == CSR_MCYCLE + 12'(cnt_off(i)));
      cnt_wr_hi[i] = wr_fire && (csr_addr_in == CSR_MCYCLEH + 12'(cnt_off(i)));
    end
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      if (wr_fire && csr_addr_in == CSR_MHPMEVENT3 + 12'(k)) event_d[k] = wr_val[EW-1:0];
    end
    if (wr_fire && csr_addr_in == CSR_MCOUNTINHIBIT) inh_d = wr_val & INH_MASK;
    if (wr_fire && csr_addr_in == CSR_MHPMOVF) ovf_d = wr_val & HPM_MASK;
    // A wrap in the same cycle as a clearing write keeps its bit set
    ovf_d = ovf_d | ovf_set;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      inh_q     <= '0;
      ovf_q     <= '0;
      ovf_irq_q <= 1'b0;
      event_q   <= '{default: '0};
    end else begin
      inh_q     <= inh_d;
      ovf_q     <= ovf_d;
      ovf_irq_q <= ovf_irq_d;
      event_q   <= event_d;
    end
  end

  for (genvar i = 0; i < NCNT; i++) begin : g_cnt
    msrv32_hpm_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt (
      .clk        (ms_riscv32_mp_clk_in),
      .rst        (ms_riscv32_mp_rst_in),
      .inc_in     (cnt_inc[i]),
      .wr_lo_in   (cnt_wr_lo[i]),
      .wr_hi_in   (cnt_wr_hi[i]),
      .wr_data_in (wr_val),
      .count_out  (cnt_val[i]),
      .wrap_out   (cnt_wrap[i])
    );
  end

  assign csr_data_out = rd_data;
  assign addr_hit_out = hit;
  assign ovf_irq_out  = ovf_irq_q;

endmodule

// File: tb/tb_msrv32_hpm_unit.sv
// Directed bench for msrv32_hpm_unit with a 40-bit counter width so that the
// high-half truncation is exercised alongside the normal counter behaviour.
module tb_msrv32_hpm_unit;

  localparam int NC = 4;
  localparam int CW = 40;
  localparam int NE = 8;

  localparam logic [2:0] OP_RW = 3'b001, OP_RS = 3'b010, OP_RC = 3'b011;
  localparam logic [2:0] OP_RWI = 3'b101, OP_RSI = 3'b110, OP_RCI = 3'b111;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [11:0]   csr_addr;
  logic [2:0]    csr_op;
  logic [4:0]    csr_uimm;
  logic [31:0]   csr_data;
  logic          instret_inc;
  logic [NE-1:0] event_in;
  logic [31:0]   csr_data_out;
  logic          addr_hit_out;
  logic          ovf_irq_out;

  logic [31:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  msrv32_hpm_unit #(
    .NUM_COUNTERS (NC),
    .COUNTER_WIDTH(CW),
    .NUM_EVENTS   (NE)
  ) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .wr_en_in            (wr_en),
    .csr_addr_in         (csr_addr),
    .csr_op_in           (csr_op),
    .csr_uimm_in         (csr_uimm),
    .csr_data_in         (csr_data),
    .instret_inc_in      (instret_inc),
    .event_in            (event_in),
    .csr_data_out        (csr_data_out),
    .addr_hit_out        (addr_hit_out),
    .ovf_irq_out         (ovf_irq_out)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drivers: every task is entered just after a falling edge and returns at one
  task automatic csr_write(input logic [11:0] addr, input logic [2:0] op,
                           input logic [31:0] data, input logic [4:0] uimm);
    csr_addr = addr;
    csr_op   = op;
    csr_data = data;
    csr_uimm = uimm;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  task automatic pulse(input logic [NE-1:0] ev, input logic inst);
    event_in    = ev;
    instret_inc = inst;
    @(negedge clk);
    event_in    = '0;
    instret_inc = 1'b0;
  endtask

  // Scoreboard: expected read data is queued with the address, popped on sample
  task automatic read_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    csr_addr = addr;
    #1;
    check(tag, csr_data_out, exp_q.pop_front());
  endtask

  task automatic hit_check(input string tag, input logic [11:0] addr, input logic exp_hit);
    csr_addr = addr;
    #1;
    check(tag, {31'b0, addr_hit_out}, {31'b0, exp_hit});
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; csr_addr = '0; csr_op = '0; csr_uimm = '0;
    csr_data = '0; instret_inc = 1'b0; event_in = '0;
    repeat (3) @(negedge clk);
    read_check("rst_mcycle", 12'hB00, 32'h0);
    read_check("rst_mcycleh", 12'hB80, 32'h0);
    check("rst_irq", {31'b0, ovf_irq_out}, 32'h0);
    rst = 1'b0;

    // Idle counting
    repeat (10) @(negedge clk);
    read_check("idle_mcycle", 12'hB00, 32'd10);
    read_check("idle_minstret", 12'hB02, 32'd0);
    check("idle_irq", {31'b0, ovf_irq_out}, 32'h0);
    hit_check("hit_b00", 12'hB00, 1'b1);

    // Event selector 2 counts event_in[1] only
    csr_write(12'h323, OP_RW, 32'd2, 5'd0);
    read_check("sel3", 12'h323, 32'd2);
    for (int i = 0; i < 5; i++) pulse(8'h02, 1'b0);
    for (int i = 0; i < 3; i++) pulse(8'h01, 1'b0);
    read_check("hpm3_cnt", 12'hB03, 32'd5);
    read_check("hpm4_idle", 12'hB04, 32'd0);

    // Wrap of counter 3 sets mhpmovf bit 3, irq follows a cycle later
    csr_write(12'h323, OP_RW, 32'd1, 5'd0);
    csr_write(12'hB03, OP_RW, 32'hFFFF_FFFF, 5'd0);
    csr_write(12'hB83, OP_RW, 32'hFFFF_FFFF, 5'd0);
    read_check("hpm3h_trunc", 12'hB83, 32'h0000_00FF);
    read_check("hpm3_ones", 12'hB03, 32'hFFFF_FFFF);
    pulse(8'h01, 1'b0);
    read_check("wrap_lo", 12'hB03, 32'h0);
    read_check("wrap_hi", 12'hB83, 32'h0);
    read_check("ovf_set", 12'h7C0, 32'h8);
    check("irq_lag", {31'b0, ovf_irq_out}, 32'h0);
    @(negedge clk);
    check("irq_high", {31'b0, ovf_irq_out}, 32'h1);
    csr_write(12'h7C0, OP_RC, 32'h8, 5'd0);
    read_check("ovf_clr", 12'h7C0, 32'h0);
    @(negedge clk);
    check("irq_low", {31'b0, ovf_irq_out}, 32'h0);

    // Wrap and clearing write on the same cycle: set wins
    csr_write(12'hB03, OP_RW, 32'hFFFF_FFFF, 5'd0);
    csr_write(12'hB83, OP_RW, 32'hFFFF_FFFF, 5'd0);
    event_in = 8'h01;
    csr_write(12'h7C0, OP_RC, 32'h8, 5'd0);
    event_in = '0;
    read_check("ovf_set_wins", 12'h7C0, 32'h8);
    csr_write(12'h7C0, OP_RW, 32'hFFFF_FFFF, 5'd0);
    read_check("ovf_mask", 12'h7C0, 32'h78);
    csr_write(12'h7C0, OP_RW, 32'h0, 5'd0);
    read_check("ovf_zero", 12'h7C0, 32'h0);

    // Inhibit
    csr_write(12'h320, OP_RW, 32'h1, 5'd0);
    csr_write(12'hB00, OP_RW, 32'h1234, 5'd0);
    repeat (5) @(negedge clk);
    read_check("mcycle_frozen", 12'hB00, 32'h1234);
    csr_write(12'h320, OP_RSI, 32'h0, 5'b00100);
    read_check("inh_rsi", 12'h320, 32'h5);
    csr_write(12'hB02, OP_RW, 32'd7, 5'd0);
    for (int i = 0; i < 3; i++) pulse(8'h00, 1'b1);
    read_check("minstret_frozen", 12'hB02, 32'd7);
    csr_write(12'h320, OP_RCI, 32'h0, 5'b00100);
    read_check("inh_rci", 12'h320, 32'h1);
    for (int i = 0; i < 2; i++) pulse(8'h00, 1'b1);
    read_check("minstret_run", 12'hB02, 32'd9);
    csr_write(12'h320, OP_RW, 32'hFFFF_FFFF, 5'd0);
    read_check("inh_mask", 12'h320, 32'h7D);
    csr_write(12'h320, OP_RW, 32'h0, 5'd0);
    csr_write(12'h320, 3'b000, 32'hFFFF_FFFF, 5'h1F);
    csr_write(12'h320, 3'b100, 32'hFFFF_FFFF, 5'h1F);
    read_check("inh_nowrite_ops", 12'h320, 32'h0);

    // Write beats a same-cycle increment; the other half is kept
    csr_write(12'hB82, OP_RW, 32'h5A, 5'd0);
    read_check("minstreth", 12'hB82, 32'h5A);
    instret_inc = 1'b1;
    csr_write(12'hB02, OP_RW, 32'h100, 5'd0);
    instret_inc = 1'b0;
    read_check("wr_beats_inc", 12'hB02, 32'h100);
    read_check("hi_kept", 12'hB82, 32'h5A);
    pulse(8'h00, 1'b1);
    read_check("inc_after_wr", 12'hB02, 32'h101);

    // Selector boundaries
    csr_write(12'h324, OP_RW, 32'd9, 5'd0);
    read_check("sel4_9", 12'h324, 32'd9);
    pulse(8'hFF, 1'b0);
    read_check("sel_out_range", 12'hB04, 32'd0);
    csr_write(12'h324, OP_RW, 32'h1F, 5'd0);
    read_check("sel_width", 12'h324, 32'hF);
    csr_write(12'h325, OP_RW, 32'd8, 5'd0);
    for (int i = 0; i < 2; i++) pulse(8'h80, 1'b0);
    read_check("sel_top_event", 12'hB05, 32'd2);
    csr_write(12'hB05, OP_RS, 32'h10, 5'd0);
    read_check("cnt_rs", 12'hB05, 32'h12);
    csr_write(12'h326, OP_RWI, 32'hFFFF_FFFF, 5'd3);
    read_check("sel_rwi", 12'h326, 32'd3);

    // Truncated high half and address decode edges
    csr_write(12'hB80, OP_RW, 32'hFFFF_FFFF, 5'd0);
    read_check("mcycleh_trunc", 12'hB80, 32'h0000_00FF);
    read_check("miss_b1f_data", 12'hB1F, 32'h0);
    hit_check("miss_b1f", 12'hB1F, 1'b0);
    hit_check("miss_b07", 12'hB07, 1'b0);
    hit_check("hit_b06", 12'hB06, 1'b1);
    hit_check("miss_327", 12'h327, 1'b0);
    hit_check("miss_b01", 12'hB01, 1'b0);

    // Reset mid-operation overrides a concurrent write
    csr_write(12'h7C0, OP_RW, 32'h10, 5'd0);
    csr_write(12'h320, OP_RW, 32'h8, 5'd0);
    rst = 1'b1;
    csr_write(12'h324, OP_RW, 32'd5, 5'd0);
    rst = 1'b0;
    read_check("rst2_sel4", 12'h324, 32'h0);
    read_check("rst2_mcycleh", 12'hB80, 32'h0);
    read_check("rst2_hpm5", 12'hB05, 32'h0);
    read_check("rst2_inh", 12'h320, 32'h0);
    read_check("rst2_ovf", 12'h7C0, 32'h0);
    check("rst2_irq", {31'b0, ovf_irq_out}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
